// File: rtl/temptop.sv
// I2S master transmitter with an internally looped-back I2S receiver.
// The transmitter sends one left and one right sample per frame of
// 2*AUDIO_DW bit clocks. The receiver listens to the transmitter's own
// lrclk/sdata and reconstructs both channels.
module temptop #(
    parameter int AUDIO_DW = 16
) (
    input  logic                sclk,
    input  logic                reset,
    input  logic [AUDIO_DW-1:0] left_tx_chan,
    input  logic [AUDIO_DW-1:0] right_tx_chan,
    output logic                lrclk_tx,
    output logic                sdata_tx,
    output logic                lrclk_rx,
    output logic                sdata_rx,
    output logic [AUDIO_DW-1:0] left_rx_chan,
    output logic [AUDIO_DW-1:0] right_rx_chan
);

    localparam int CW = $clog2(2 * AUDIO_DW);
    localparam int IW = $clog2(AUDIO_DW);
    localparam logic [CW-1:0] CNT_MAX  = CW'(2 * AUDIO_DW - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(AUDIO_DW);

    // Transmit state
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AUDIO_DW-1:0] hold_l_q, hold_l_d;
    logic [AUDIO_DW-1:0] hold_r_q, hold_r_d;
    logic                lrclk_tx_q, lrclk_tx_d;
    logic                sdata_tx_q, sdata_tx_d;
    logic [IW-1:0]       bit_idx;

    // Receive state; the shift register only needs AUDIO_DW-1 bits because
    // the last bit of each word is taken straight from the serial line.
    logic [AUDIO_DW-2:0] shift_q, shift_d;
    logic                rx_lrclk_q;
    logic [AUDIO_DW-1:0] rx_word;
    logic [AUDIO_DW-1:0] left_q, left_d;
    logic [AUDIO_DW-1:0] right_q, right_d;

    // Transmitter next state: frame counter, sample capture at cnt==0, and
    // the bit to present after this edge (one-bit delay behind lrclk).
    always_comb begin
        cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        hold_l_d   = (cnt_q == '0) ? left_tx_chan  : hold_l_q;
        hold_r_d   = (cnt_q == '0) ? right_tx_chan : hold_r_q;
        lrclk_tx_d = (cnt_d >= CNT_HALF);
        bit_idx    = '0;
        sdata_tx_d = hold_r_d[0];
        if (cnt_d == '0) begin
            // Last right bit spills into the first slot of the next frame.
            sdata_tx_d = hold_r_d[0];
        end else if (cnt_d <= CNT_HALF) begin
            bit_idx    = IW'(AUDIO_DW - int'(cnt_d));
            sdata_tx_d = hold_l_d[bit_idx];
        end else begin
            bit_idx    = IW'(2 * AUDIO_DW - int'(cnt_d));
            sdata_tx_d = hold_r_d[bit_idx];
        end
    end

    // Transmitter registers.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            lrclk_tx_q <= 1'b0;
            sdata_tx_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            lrclk_tx_q <= lrclk_tx_d;
            sdata_tx_q <= sdata_tx_d;
        end
    end

    assign lrclk_tx = lrclk_tx_q;
    assign sdata_tx = sdata_tx_q;

    // Loopback path into the receiver.
    assign lrclk_rx = lrclk_tx;
    assign sdata_rx = sdata_tx;

    // Receiver next state: a word completes on any lrclk transition, and the
    // bit on the line at that edge is the word's LSB. Reset leaves
    // rx_lrclk_q equal to the reset lrclk, so no boundary follows reset.
    always_comb begin
        rx_word = {shift_q, sdata_rx};
        shift_d = rx_word[AUDIO_DW-2:0];
        left_d  = left_q;
        right_d = right_q;
        if (lrclk_rx && !rx_lrclk_q) begin
            left_d = rx_word;
        end
        if (!lrclk_rx && rx_lrclk_q) begin
            right_d = rx_word;
        end
    end

    // Receiver registers.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            shift_q    <= '0;
            rx_lrclk_q <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
        end else begin
            shift_q    <= shift_d;
            rx_lrclk_q <= lrclk_rx;
            left_q     <= left_d;
            right_q    <= right_d;
        end
    end

    assign left_rx_chan  = left_q;
    assign right_rx_chan = right_q;

endmodule

// File: tb/tb_temptop.sv
// Directed bench for temptop: a 16-bit instance for the main scenarios and
// an 8-bit instance for the narrow-word configuration.
module tb_temptop;

    logic        sclk;
    logic        rst16;
    logic        rst8;
    logic [15:0] l16_tx, r16_tx, l16_rx, r16_rx;
    logic        lr16_tx, sd16_tx, lr16_rx, sd16_rx;
    logic [7:0]  l8_tx, r8_tx, l8_rx, r8_rx;
    logic        lr8_tx, sd8_tx, lr8_rx, sd8_rx;

    int n_checks;
    int n_fail;
    int tcnt;  // bench's own view of the 16-bit frame position

    temptop #(.AUDIO_DW(16)) dut16 (
        .sclk          (sclk),
        .reset         (rst16),
        .left_tx_chan  (l16_tx),
        .right_tx_chan (r16_tx),
        .lrclk_tx      (lr16_tx),
        .sdata_tx      (sd16_tx),
        .lrclk_rx      (lr16_rx),
        .sdata_rx      (sd16_rx),
        .left_rx_chan  (l16_rx),
        .right_rx_chan (r16_rx)
    );

    temptop #(.AUDIO_DW(8)) dut8 (
        .sclk          (sclk),
        .reset         (rst8),
        .left_tx_chan  (l8_tx),
        .right_tx_chan (r8_tx),
        .lrclk_tx      (lr8_tx),
        .sdata_tx      (sd8_tx),
        .lrclk_rx      (lr8_rx),
        .sdata_rx      (sd8_rx),
        .left_rx_chan  (l8_rx),
        .right_rx_chan (r8_rx)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick16();
        @(posedge sclk);
        #1;
        if (rst16) tcnt = 0;
        else       tcnt = (tcnt + 1) % 32;
    endtask

    task automatic wait_cnt(input int target);
        do tick16(); while (tcnt != target);
    endtask

    task automatic test_reset();
        rst16  = 1'b1;
        l16_tx = 16'h4567;
        r16_tx = 16'hCDEF;
        tick16();
        tick16();
        n_checks++; if (lr16_tx !== 1'b0)    begin n_fail++; $display("FAIL reset_lrclk: got %b want 0", lr16_tx); end
        n_checks++; if (sd16_tx !== 1'b0)    begin n_fail++; $display("FAIL reset_sdata: got %b want 0", sd16_tx); end
        n_checks++; if (l16_rx !== 16'h0000) begin n_fail++; $display("FAIL reset_left: got %h want 0000", l16_rx); end
        n_checks++; if (r16_rx !== 16'h0000) begin n_fail++; $display("FAIL reset_right: got %h want 0000", r16_rx); end
    endtask

    task automatic test_loopback();
        logic [15:0] cap_l, cap_r;
        cap_l = '0;
        cap_r = '0;
        rst16 = 1'b0;
        tcnt  = 0;
        for (int e = 1; e <= 33; e++) begin
            tick16();
            n_checks++;
            if (lr16_tx !== (tcnt >= 16)) begin
                n_fail++; $display("FAIL wave_lrclk edge %0d: got %b want %b", e, lr16_tx, (tcnt >= 16));
            end
            if (e >= 1 && e <= 16)  cap_l = {cap_l[14:0], sd16_tx};
            if (e >= 17 && e <= 32) cap_r = {cap_r[14:0], sd16_tx};
            if (e == 16) begin
                n_checks++; if (l16_rx !== 16'h0000) begin n_fail++; $display("FAIL loop_left_early: got %h want 0000", l16_rx); end
            end
            if (e == 17) begin
                n_checks++; if (l16_rx !== 16'h4567) begin n_fail++; $display("FAIL loop_left: got %h want 4567", l16_rx); end
            end
            if (e == 32) begin
                n_checks++; if (r16_rx !== 16'h0000) begin n_fail++; $display("FAIL loop_right_early: got %h want 0000", r16_rx); end
            end
            if (e == 33) begin
                n_checks++; if (r16_rx !== 16'hCDEF) begin n_fail++; $display("FAIL loop_right: got %h want CDEF", r16_rx); end
            end
        end
        n_checks++; if (cap_l !== 16'h4567) begin n_fail++; $display("FAIL wave_left_bits: got %h want 4567", cap_l); end
        n_checks++; if (cap_r !== 16'hCDEF) begin n_fail++; $display("FAIL wave_right_bits: got %h want CDEF", cap_r); end
        for (int e = 0; e < 64; e++) begin
            tick16();
            n_checks++;
            if (l16_rx !== 16'h4567 || r16_rx !== 16'hCDEF) begin
                n_fail++; $display("FAIL loop_stable: got %h/%h want 4567/CDEF", l16_rx, r16_rx);
            end
        end
    endtask

    task automatic test_mid_change();
        wait_cnt(5);
        l16_tx = 16'h1234;
        wait_cnt(17);
        n_checks++; if (l16_rx !== 16'h4567) begin n_fail++; $display("FAIL midchg_current: got %h want 4567", l16_rx); end
        wait_cnt(17);
        n_checks++; if (l16_rx !== 16'h1234) begin n_fail++; $display("FAIL midchg_next: got %h want 1234", l16_rx); end
        wait_cnt(1);
        n_checks++; if (r16_rx !== 16'hCDEF) begin n_fail++; $display("FAIL midchg_right: got %h want CDEF", r16_rx); end
    endtask

    task automatic test_mid_reset();
        wait_cnt(10);
        rst16 = 1'b1;
        #1;
        n_checks++; if (lr16_tx !== 1'b0 || sd16_tx !== 1'b0) begin n_fail++; $display("FAIL midrst_tx: got %b%b want 00", lr16_tx, sd16_tx); end
        n_checks++; if (l16_rx !== 16'h0000) begin n_fail++; $display("FAIL midrst_left: got %h want 0000", l16_rx); end
        n_checks++; if (r16_rx !== 16'h0000) begin n_fail++; $display("FAIL midrst_right: got %h want 0000", r16_rx); end
        l16_tx = 16'hBEEF;
        r16_tx = 16'h0F0F;
        tick16();
        tick16();
        rst16 = 1'b0;
        tcnt  = 0;
        for (int e = 1; e <= 33; e++) begin
            tick16();
            if (e == 1 || e == 16) begin
                n_checks++; if (l16_rx !== 16'h0000) begin n_fail++; $display("FAIL midrst_left_hold edge %0d: got %h want 0000", e, l16_rx); end
            end
            if (e == 17) begin
                n_checks++; if (l16_rx !== 16'hBEEF) begin n_fail++; $display("FAIL midrst_left_new: got %h want BEEF", l16_rx); end
            end
            if (e == 32) begin
                n_checks++; if (r16_rx !== 16'h0000) begin n_fail++; $display("FAIL midrst_right_hold: got %h want 0000", r16_rx); end
            end
            if (e == 33) begin
                n_checks++; if (r16_rx !== 16'h0F0F) begin n_fail++; $display("FAIL midrst_right_new: got %h want 0F0F", r16_rx); end
            end
        end
    endtask

    task automatic test_extreme();
        logic [15:0] pl [2];
        logic [15:0] pr [2];
        logic        want;
        pl[0] = 16'h0000; pr[0] = 16'hFFFF;
        pl[1] = 16'hFFFF; pr[1] = 16'h0000;
        for (int p = 0; p < 2; p++) begin
            wait_cnt(20);
            l16_tx = pl[p];
            r16_tx = pr[p];
            wait_cnt(1);
            for (int k = 0; k < 32; k++) begin
                if (tcnt >= 1 && tcnt <= 16) want = pl[p][16 - tcnt];
                else if (tcnt == 0)          want = pr[p][0];
                else                         want = pr[p][32 - tcnt];
                n_checks++;
                if (sd16_tx !== want) begin
                    n_fail++; $display("FAIL extreme_sdata p%0d cnt %0d: got %b want %b", p, tcnt, sd16_tx, want);
                end
                tick16();
            end
            n_checks++; if (l16_rx !== pl[p]) begin n_fail++; $display("FAIL extreme_left p%0d: got %h want %h", p, l16_rx, pl[p]); end
            n_checks++; if (r16_rx !== pr[p]) begin n_fail++; $display("FAIL extreme_right p%0d: got %h want %h", p, r16_rx, pr[p]); end
        end
    endtask

    task automatic test_param8();
        l8_tx = 8'hA5;
        r8_tx = 8'h3C;
        tick16();
        n_checks++; if (l8_rx !== 8'h00 || r8_rx !== 8'h00) begin n_fail++; $display("FAIL p8_reset: got %h/%h want 00/00", l8_rx, r8_rx); end
        rst8 = 1'b0;
        for (int e = 1; e <= 33; e++) begin
            tick16();
            n_checks++;
            if (lr8_tx !== ((e % 16) >= 8)) begin
                n_fail++; $display("FAIL p8_lrclk edge %0d: got %b want %b", e, lr8_tx, ((e % 16) >= 8));
            end
            if (e == 8) begin
                n_checks++; if (l8_rx !== 8'h00) begin n_fail++; $display("FAIL p8_left_early: got %h want 00", l8_rx); end
            end
            if (e == 9) begin
                n_checks++; if (l8_rx !== 8'hA5) begin n_fail++; $display("FAIL p8_left: got %h want A5", l8_rx); end
            end
            if (e == 16) begin
                n_checks++; if (r8_rx !== 8'h00) begin n_fail++; $display("FAIL p8_right_early: got %h want 00", r8_rx); end
            end
            if (e == 17 || e == 33) begin
                n_checks++; if (l8_rx !== 8'hA5 || r8_rx !== 8'h3C) begin n_fail++; $display("FAIL p8_both edge %0d: got %h/%h want A5/3C", e, l8_rx, r8_rx); end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tcnt     = 0;
        rst16    = 1'b1;
        rst8     = 1'b1;
        l16_tx   = '0;
        r16_tx   = '0;
        l8_tx    = '0;
        r8_tx    = '0;
        test_reset();
        test_loopback();
        test_mid_change();
        test_mid_reset();
        test_extreme();
        test_param8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/temptop.md
TEMPTOP -- requirements
Module: temptop

Interface
REQ-001 Parameter: AUDIO_DW, default 16, audio sample width in bits; legal values are powers of two, 4..32.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-003 sclk  input  1  I2S bit clock; all logic on rising edge; the only clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 left_tx_chan  input  AUDIO_DW  left sample to transmit.
REQ-006 right_tx_chan  input  AUDIO_DW  right sample to transmit.
REQ-007 lrclk_tx  output  1  transmit word-select; 0 = left slot, 1 = right slot.
REQ-008 sdata_tx  output  1  transmit serial data, MSB first, I2S format.
REQ-009 lrclk_rx  output  1  receive word-select, internal loopback copy of lrclk_tx.
REQ-010 sdata_rx  output  1  receive serial data, internal loopback copy of sdata_tx.
REQ-011 left_rx_chan  output  AUDIO_DW  last fully received left sample.
REQ-012 right_rx_chan  output  AUDIO_DW  last fully received right sample.

Function
REQ-013 Block SHALL be an I2S master transmitter plus I2S receiver, with the receiver fed by a combinational loopback: lrclk_rx = lrclk_tx and sdata_rx = sdata_tx.
REQ-014 Frame counter cnt SHALL run 0..2*AUDIO_DW-1, incrementing every rising sclk edge and wrapping from 2*AUDIO_DW-1 to 0.
REQ-015 lrclk_tx SHALL be 0 while cnt < AUDIO_DW and 1 while cnt >= AUDIO_DW.
REQ-016 On the edge where cnt==0, the block SHALL capture left_tx_chan and right_tx_chan into hold registers; input changes at any other time SHALL NOT affect the current frame.
REQ-017 sdata_tx SHALL be registered and follow the one-bit I2S delay after each lrclk transition.
REQ-018 While cnt==c with 1<=c<=AUDIO_DW, sdata_tx SHALL equal held_left[AUDIO_DW-c].
REQ-019 While cnt==c with AUDIO_DW+1<=c<=2*AUDIO_DW-1, sdata_tx SHALL equal held_right[2*AUDIO_DW-c].
REQ-020 While cnt==0, sdata_tx SHALL equal held_right[0] of the previous frame.
REQ-021 Receiver SHALL sample sdata_rx on every rising edge into a shift register that shifts in at the LSB.
REQ-022 Receiver SHALL keep lrclk_d, lrclk_rx registered each edge; a word boundary is any edge where lrclk_rx != lrclk_d.
REQ-023 On a 0->1 boundary, left_rx_chan SHALL load {shift[AUDIO_DW-2:0], sdata_rx}.
REQ-024 On a 1->0 boundary, right_rx_chan SHALL load {shift[AUDIO_DW-2:0], sdata_rx}.
REQ-025 Rx outputs SHALL hold their value between boundaries.
REQ-026 Latency: a frame captured at edge N SHALL appear on left_rx_chan at edge N+AUDIO_DW and on right_rx_chan at edge N+2*AUDIO_DW.
REQ-027 With reset released before edge 1, the first capture SHALL occur at edge 1, left_rx_chan SHALL be valid after edge 17, and right_rx_chan after edge 33 (AUDIO_DW=16).

Reset
REQ-028 While reset is high, cnt, lrclk_tx, sdata_tx, lrclk_d, the shift register, the hold registers, left_rx_chan and right_rx_chan SHALL all be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; the partial word SHALL NOT be written to any rx output.
REQ-030 After reset release, operation SHALL restart with cnt=0 at the next rising edge.
REQ-031 The lrclk_d=0 reset state SHALL NOT create a spurious boundary at the first edge after reset.

Verification
REQ-032 Basic loopback: reset for 1 cycle, left_tx=16'h4567, right_tx=16'hCDEF -> after edge 33, left_rx_chan=16'h4567 and right_rx_chan=16'hCDEF; both stable on all following frames.
REQ-033 Waveform check: lrclk_tx SHALL be low for 16 cycles then high for 16 cycles, repeating; sdata_tx over cnt=1..16 SHALL read 0100_0101_0110_0111 (16'h4567, MSB first).
REQ-034 Mid-frame input change: change left_tx to 16'h1234 at cnt=5 -> current frame still delivers 16'h4567; the next frame delivers 16'h1234.
REQ-035 Mid-frame reset: assert reset at cnt=10 -> all outputs 0 immediately; after release, rx outputs update only after a full new frame.
REQ-036 Extreme values: left_tx=16'h0000, right_tx=16'hFFFF, then swapped -> rx outputs match exactly; no bit slip at the frame wrap.
REQ-037 Parameter: AUDIO_DW=8 with left_tx=8'hA5, right_tx=8'h3C -> lrclk period 16 cycles; rx values correct after edge 17.
